// File: rtl/decode_stage.sv
// Single-entry decode stage: registers an RV32I/M instruction plus decoded fields,
// and parks the custom ENC instruction until the encryption accelerator reports done.
module decode_stage #(
  parameter int         ADDRESS_BITS = 16,
  parameter logic [6:0] ENC_OPCODE   = 7'h0B
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] in_pc,
  input  logic [31:0]             in_instr,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_pc,
  output logic [6:0]              op,
  output logic [2:0]              funct3,
  output logic [6:0]              funct7,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wen,
  output logic [31:0]             imm32,
  output logic [ADDRESS_BITS-1:0] target_pc,
  output logic                    is_muldiv,
  output logic                    is_enc,
  output logic                    illegal,
  output logic                    enc_start,
  input  logic                    enc_done,
  output logic                    enc_abort
);

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef enum logic [1:0] {EMPTY, FULL, ENC_WAIT} state_e;

  typedef struct packed {
    logic [ADDRESS_BITS-1:0] pc;
    logic [ADDRESS_BITS-1:0] tgt;
    logic [6:0]              op;
    logic [2:0]              f3;
    logic [6:0]              f7;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic [31:0]             imm;
    logic                    wen;
    logic                    md;
    logic                    enc;
    logic                    ill;
  } dec_t;

  state_e state_q, state_d;
  dec_t   dec_q, dec_d;
  logic   enc_start_q, enc_abort_q;
  logic   ready_c, capture, wr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    dec_d     = '0;
    wr        = 1'b0;
    dec_d.pc  = in_pc;
    dec_d.op  = in_instr[6:0];
    dec_d.rd  = in_instr[11:7];
    dec_d.f3  = in_instr[14:12];
    dec_d.rs1 = in_instr[19:15];
    dec_d.rs2 = in_instr[24:20];
    dec_d.f7  = in_instr[31:25];
    // ENC is tested first so a parameter that aliases a standard opcode still wins.
    if (in_instr[6:0] == ENC_OPCODE) begin
      dec_d.enc = 1'b1;
      wr        = 1'b1;
    end else begin
      case (in_instr[6:0])
        OPC_OP: begin
          wr       = 1'b1;
          dec_d.md = (in_instr[31:25] == 7'h01);
        end
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          wr        = 1'b1;
          dec_d.imm = imm_i;
        end
        OPC_MISC_MEM, OPC_SYSTEM: dec_d.imm = imm_i;
        OPC_STORE:                dec_d.imm = imm_s;
        OPC_BRANCH: begin
          dec_d.imm = imm_b;
          dec_d.tgt = in_pc + imm_b[ADDRESS_BITS-1:0];
        end
        OPC_LUI, OPC_AUIPC: begin
          wr        = 1'b1;
          dec_d.imm = imm_u;
        end
        OPC_JAL: begin
          wr        = 1'b1;
          dec_d.imm = imm_j;
          dec_d.tgt = in_pc + imm_j[ADDRESS_BITS-1:0];
        end
        default: dec_d.ill = 1'b1;
      endcase
    end
    dec_d.wen = wr && (in_instr[11:7] != 5'd0);
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    case (state_q)
      EMPTY: begin
        ready_c = 1'b1;
        if (in_valid) state_d = dec_d.enc ? ENC_WAIT : FULL;
      end
      FULL: begin
        ready_c = out_ready;
        if (out_ready) begin
          if (in_valid) state_d = dec_d.enc ? ENC_WAIT : FULL;
          else          state_d = EMPTY;
        end
      end
      ENC_WAIT: if (enc_done) state_d = FULL;
      default:  state_d = EMPTY;
    endcase
    // Flush overrides everything; dropping ready keeps fetch from thinking it was taken.
    if (flush) begin
      state_d = EMPTY;
      ready_c = 1'b0;
    end
  end

  assign in_ready = ready_c && !reset;
  assign capture  = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      dec_q       <= '0;
      enc_start_q <= 1'b0;
      enc_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      enc_start_q <= capture && dec_d.enc;
      enc_abort_q <= flush && (state_q == ENC_WAIT);
      if (capture) dec_q <= dec_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_pc    = dec_q.pc;
  assign op        = dec_q.op;
  assign funct3    = dec_q.f3;
  assign funct7    = dec_q.f7;
  assign read_sel1 = dec_q.rs1;
  assign read_sel2 = dec_q.rs2;
  assign write_sel = dec_q.rd;
  assign wen       = dec_q.wen;
  assign imm32     = dec_q.imm;
  assign target_pc = dec_q.tgt;
  assign is_muldiv = dec_q.md;
  assign is_enc    = dec_q.enc;
  assign illegal   = dec_q.ill;
  assign enc_start = enc_start_q;
  assign enc_abort = enc_abort_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected decodes are queued on each accepted
// instruction and compared when execute takes the decoded output.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset, in_valid, flush, out_ready, enc_done;
  logic [15:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready, out_valid, wen, is_muldiv, is_enc, illegal, enc_start, enc_abort;
  logic [15:0] out_pc, target_pc;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;
  logic [4:0]  read_sel1, read_sel2, write_sel;
  logic [31:0] imm32;

  decode_stage #(.ADDRESS_BITS(16), .ENC_OPCODE(7'h0B)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .op(op), .funct3(funct3), .funct7(funct7),
    .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel), .wen(wen),
    .imm32(imm32), .target_pc(target_pc), .is_muldiv(is_muldiv), .is_enc(is_enc),
    .illegal(illegal), .enc_start(enc_start), .enc_done(enc_done), .enc_abort(enc_abort)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic        wen;
    logic [31:0] imm;
    logic [15:0] tgt;
    logic        chk_tgt;
    logic        md, enc, ill;
  } exp_t;

  exp_t sb[$];
  exp_t cur, got;
  int   tests = 0, failed = 0;
  int   n_pop = 0, n_start = 0, n_abort = 0;
  logic toggle = 1'b0;
  logic stall_prev = 1'b0;
  logic [15:0] snap_pc;
  logic [31:0] snap_imm;
  logic [4:0]  snap_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] pc, input logic [31:0] instr,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic w, input logic [31:0] imm,
                              input logic [15:0] tgt, input logic chk_tgt,
                              input logic md, input logic enc, input logic ill);
    exp_t e;
    e.pc = pc; e.op = instr[6:0]; e.f3 = instr[14:12]; e.f7 = instr[31:25];
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.wen = w; e.imm = imm;
    e.tgt = tgt; e.chk_tgt = chk_tgt; e.md = md; e.enc = enc; e.ill = ill;
    return e;
  endfunction

  task automatic compare_out(input exp_t e);
    check("out_pc", out_pc, e.pc);
    check("op", op, e.op);
    check("funct3", funct3, e.f3);
    check("funct7", funct7, e.f7);
    check("read_sel1", read_sel1, e.rs1);
    check("read_sel2", read_sel2, e.rs2);
    check("write_sel", write_sel, e.rd);
    check("wen", wen, e.wen);
    check("imm32", imm32, e.imm);
    if (e.chk_tgt) check("target_pc", target_pc, e.tgt);
    check("is_muldiv", is_muldiv, e.md);
    check("is_enc", is_enc, e.enc);
    check("illegal", illegal, e.ill);
  endtask

  // Monitor: mid-cycle sampling, away from the rising edge.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (enc_start) n_start++;
      if (enc_abort) n_abort++;
      if (stall_prev && out_valid) begin
        check("stall_pc", out_pc, snap_pc);
        check("stall_imm", imm32, snap_imm);
        check("stall_rd", write_sel, snap_rd);
      end
      stall_prev = out_valid && !out_ready;
      snap_pc = out_pc; snap_imm = imm32; snap_rd = write_sel;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", out_valid, 1'b0);
        else begin
          got = sb.pop_front();
          n_pop++;
          compare_out(got);
        end
      end
      if (flush) sb.delete();
      if (in_valid && in_ready) sb.push_back(cur);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
    if (toggle) out_ready = ~out_ready;
  endtask

  task automatic send(input logic [15:0] pc, input logic [31:0] instr, input exp_t e,
                      output int tries);
    logic acc;
    in_valid = 1'b1; in_pc = pc; in_instr = instr; cur = e;
    tries = 0;
    do begin
      @(negedge clock); #1;
      acc = in_ready;
      tries++;
      tick();
    end while (!acc && tries < 50);
    if (!acc) check("accept_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_queue", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries, p0, s0, a0;
    logic [11:0] im;
    logic [31:0] w;
    in_valid = 0; flush = 0; out_ready = 1; enc_done = 0; in_pc = 0; in_instr = 0;
    reset = 0;
    #1 reset = 1;
    @(posedge clock); #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_enc_start", enc_start, 0);
    check("rst_enc_abort", enc_abort, 0);
    check("rst_imm32", imm32, 0);
    check("rst_write_sel", write_sel, 0);
    check("rst_out_pc", out_pc, 0);
    @(negedge clock) reset = 0;
    #1 check("post_rst_in_ready", in_ready, 1);
    tick();

    // Directed decodes, back-to-back with execute always ready.
    send(16'h0000, 32'h00500113, mk(16'h0000, 32'h00500113, 5'd2, 5'd0, 5'd5, 1, 32'd5, 0, 0, 0, 0, 0), tries);
    check("latency_out_valid", out_valid, 1);
    send(16'h0004, 32'hFF718393, mk(16'h0004, 32'hFF718393, 5'd7, 5'd3, 5'h17, 1, 32'hFFFFFFF7, 0, 0, 0, 0, 0), tries);
    check("no_bubble_tries", tries, 1);
    send(16'h0010, 32'h02728863, mk(16'h0010, 32'h02728863, 5'd16, 5'd5, 5'd7, 0, 32'h30, 16'h0040, 1, 0, 0, 0), tries);
    send(16'hFFF0, 32'h02728863, mk(16'hFFF0, 32'h02728863, 5'd16, 5'd5, 5'd7, 0, 32'h30, 16'h0020, 1, 0, 0, 0), tries);
    send(16'h0100, 32'h008000EF, mk(16'h0100, 32'h008000EF, 5'd1, 5'd0, 5'd8, 1, 32'd8, 16'h0108, 1, 0, 0, 0), tries);
    send(16'h0104, 32'h12345037, mk(16'h0104, 32'h12345037, 5'd0, 5'd8, 5'd3, 0, 32'h12345000, 0, 0, 0, 0, 0), tries);
    send(16'h0108, 32'h022081B3, mk(16'h0108, 32'h022081B3, 5'd3, 5'd1, 5'd2, 1, 32'd0, 0, 0, 1, 0, 0), tries);
    check("no_bubble_tries2", tries, 1);
    send(16'h010C, 32'h0000007F, mk(16'h010C, 32'h0000007F, 5'd0, 5'd0, 5'd0, 0, 32'd0, 0, 0, 0, 0, 1), tries);
    send(16'h0110, 32'h0000057F, mk(16'h0110, 32'h0000057F, 5'd10, 5'd0, 5'd0, 0, 32'd0, 0, 0, 0, 0, 1), tries);
    wait_drain();

    // Held output while execute stalls for several cycles.
    out_ready = 0;
    send(16'h0200, 32'h00500113, mk(16'h0200, 32'h00500113, 5'd2, 5'd0, 5'd5, 1, 32'd5, 0, 0, 0, 0, 0), tries);
    tick(); tick(); tick();
    check("stalled_out_valid", out_valid, 1);
    check("stalled_in_ready", in_ready, 0);
    out_ready = 1;
    wait_drain();

    // Back-to-back stream with out_ready toggling every cycle.
    p0 = n_pop;
    toggle = 1'b1;
    for (int i = 0; i < 10; i++) begin
      im = 12'(i * 300 - 900);
      w  = {im, 5'(i), 3'b000, 5'(i + 1), 7'h13};
      send(16'(16'h0300 + 4 * i), w,
           mk(16'(16'h0300 + 4 * i), w, 5'(i + 1), 5'(i), im[4:0], 1,
              {{20{im[11]}}, im}, 0, 0, 0, 0, 0), tries);
    end
    wait_drain();
    toggle = 1'b0;
    out_ready = 1;
    tick();
    check("stream_count", n_pop - p0, 10);

    // ENC instruction completes through the accelerator.
    s0 = n_start;
    send(16'h0400, 32'h0041A20B, mk(16'h0400, 32'h0041A20B, 5'd4, 5'd3, 5'd4, 1, 32'd0, 0, 0, 0, 1, 0), tries);
    check("enc_start_pulse", enc_start, 1);
    check("enc_wait_out_valid", out_valid, 0);
    tick();
    check("enc_start_drop", enc_start, 0);
    check("enc_wait_in_ready", in_ready, 0);
    tick(); tick();
    check("enc_wait_out_valid2", out_valid, 0);
    enc_done = 1;
    tick();
    enc_done = 0;
    check("enc_done_out_valid", out_valid, 1);
    wait_drain();
    check("enc_start_count", n_start - s0, 1);

    // ENC flushed while waiting; a simultaneous done must be ignored.
    a0 = n_abort;
    send(16'h0500, 32'h0041A20B, mk(16'h0500, 32'h0041A20B, 5'd4, 5'd3, 5'd4, 1, 32'd0, 0, 0, 0, 1, 0), tries);
    tick(); tick();
    flush = 1; enc_done = 1;
    tick();
    flush = 0; enc_done = 0;
    check("enc_abort_pulse", enc_abort, 1);
    check("flush_out_valid", out_valid, 0);
    tick();
    check("enc_abort_drop", enc_abort, 0);
    tick(); tick();
    check("flush_out_valid2", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("enc_abort_count", n_abort - a0, 1);
    check("flush_queue", sb.size(), 0);

    // Reset while waiting on the accelerator must not abort it.
    a0 = n_abort;
    send(16'h0600, 32'h0041A20B, mk(16'h0600, 32'h0041A20B, 5'd4, 5'd3, 5'd4, 1, 32'd0, 0, 0, 0, 1, 0), tries);
    tick();
    #1 reset = 1;
    #1;
    check("rst_enc_abort_now", enc_abort, 0);
    check("rst_is_enc", is_enc, 0);
    @(negedge clock) reset = 0;
    tick(); tick();
    check("rst_no_abort", n_abort - a0, 0);
    check("rst_recover_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ADDRESS_BITS, default 16, width of all PC and target fields.
REQ-002 Parameter ENC_OPCODE, default 7'h0B, opcode of the custom encryption instruction.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  fetch presents an instruction.
REQ-007 in_ready  out  1  stage accepts an instruction this cycle.
REQ-008 in_pc  in  ADDRESS_BITS  PC of the presented instruction.
REQ-009 in_instr  in  32  raw instruction word.
REQ-010 flush  in  1  discard held instruction (branch/JALR redirect).
REQ-011 out_valid  out  1  decoded instruction valid.
REQ-012 out_ready  in  1  execute accepts the decoded instruction.
REQ-013 out_pc  out  ADDRESS_BITS  registered PC.
REQ-014 op, funct3, funct7  out  7/3/7  instruction fields.
REQ-015 read_sel1, read_sel2, write_sel  out  5 each  rs1, rs2, rd.
REQ-016 wen  out  1  register write enable.
REQ-017 imm32  out  32  sign-extended immediate.
REQ-018 target_pc  out  ADDRESS_BITS  out_pc + imm32 for JAL/branch.
REQ-019 is_muldiv, is_enc, illegal  out  1 each  M-extension op, ENC op, unknown opcode.
REQ-020 enc_start  out  1  one-cycle start pulse to encryption accelerator.
REQ-021 enc_done  in  1  accelerator completion.
REQ-022 enc_abort  out  1  one-cycle cancel pulse to accelerator.

Function
REQ-023 States SHALL be EMPTY, FULL and ENC_WAIT.
REQ-024 EMPTY: out_valid=0, in_ready=1; in_valid captures the instruction and goes to FULL, or to ENC_WAIT when op==ENC_OPCODE.
REQ-025 FULL: out_valid=1, in_ready=out_ready.
REQ-026 FULL: when out_valid&&out_ready&&in_valid, capture the new instruction in the same cycle (back-to-back, no bubble).
REQ-027 FULL: when out_valid&&out_ready without in_valid, go to EMPTY.
REQ-028 FULL: when out_ready=0, hold all outputs stable.
REQ-029 Entering ENC_WAIT SHALL assert enc_start for exactly one cycle, on the capture edge.
REQ-030 ENC_WAIT: out_valid=0, in_ready=0; enc_done goes to FULL, and the ENC instruction is presented once with is_enc=1.
REQ-031 Latency: in handshake to out_valid is 1 cycle for non-ENC instructions, and 1 cycle after enc_done for ENC.
REQ-032 flush SHALL have highest priority: next state EMPTY, in_valid ignored that cycle.
REQ-033 flush in ENC_WAIT SHALL pulse enc_abort for one cycle; enc_done in the same cycle is ignored.
REQ-034 Immediates: I, S, B, U and J formats per RV32I, sign-extended from bit 31; R-type and ENC give imm32=0.
REQ-035 wen=1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC and ENC, and only when rd!=0.
REQ-036 is_muldiv=1 when op==7'h33 and funct7==7'h01.
REQ-037 Unknown opcode: illegal=1, wen=0, passed downstream normally.
REQ-038 target_pc SHALL wrap modulo 2^ADDRESS_BITS.
REQ-039 Decoded fields SHALL be registered from in_instr at capture; no combinational path from in_instr to outputs.

Reset
REQ-040 Reset SHALL force EMPTY and zero every output, including out_valid, enc_start and enc_abort.
REQ-041 After reset deassertion, in_ready=1.
REQ-042 Reset asserted in ENC_WAIT SHALL NOT generate enc_abort.

Verification
REQ-043 in_instr=32'h00500113 at pc 0 -> next cycle out_valid=1, write_sel=2, read_sel1=0, imm32=5, wen=1.
REQ-044 in_instr=32'hFF718393 -> imm32=32'hFFFFFFF7, read_sel1=3, write_sel=7.
REQ-045 beq 32'h02728863 at pc 16'h0010 -> imm32=32'h30, target_pc=16'h0040; same word at pc 16'hFFF0 -> target_pc=16'h0020.
REQ-046 Back-to-back stream with out_ready toggled 1/0 -> no instruction lost or duplicated, outputs stable while stalled.
REQ-047 in_instr=32'h0041A20B -> enc_start pulses once, out_valid=0 until enc_done, then out_valid=1 with is_enc=1, write_sel=4, read_sel1=3, read_sel2=4; repeat with flush in ENC_WAIT -> enc_abort pulses once and out_valid stays 0.
REQ-048 in_instr=32'h022081B3 -> is_muldiv=1, write_sel=3; in_instr=32'h0000007F -> illegal=1, wen=0.
